// File: rtl/load_scoreboard_hazard.sv
// Load-use hazard unit: in-order FIFO scoreboard of outstanding load destinations.
// Optional stall performance counter enabled by defining HAZARD_STALL_PERF_EN.
module load_scoreboard_hazard #(
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 4,
  parameter int WB_BYPASS = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       id_valid_i,
  input  logic [REG_AW-1:0]          id_rs1_i,
  input  logic [REG_AW-1:0]          id_rs2_i,
  input  logic                       id_rs1_used_i,
  input  logic                       id_rs2_used_i,
  input  logic                       id_memread_i,
  input  logic [REG_AW-1:0]          id_rd_i,
  input  logic                       flush_i,
  input  logic                       wb_load_valid_i,
  output logic                       stall_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
`ifdef HAZARD_STALL_PERF_EN
  input  logic                       stall_cnt_clr_i,
  output logic [31:0]                stall_cnt_o,
`endif
  output logic                       underflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) n = {PW{1'b0}};
    else                     n = p + PW'(1);
    return n;
  endfunction

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [REG_AW-1:0] rd_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              underflow_q, underflow_d;

  logic [DEPTH-1:0]  live_s;
  logic              rs1_hit_s, rs2_hit_s, rs1_match_s, rs2_match_s;
  logic              full_s, empty_s, stall_s, alloc_s, retire_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  // Source match against live entries; the retiring head is bypassed when enabled.
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    live_s    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_s[i] = valid_q[i] &&
                  !((WB_BYPASS != 0) && wb_load_valid_i && (head_q == PW'(i)));
      rs1_hit_s = rs1_hit_s | (live_s[i] && (rd_q[i] == id_rs1_i));
      rs2_hit_s = rs2_hit_s | (live_s[i] && (rd_q[i] == id_rs2_i));
    end
  end

  assign rs1_match_s = id_rs1_used_i && (id_rs1_i != {REG_AW{1'b0}}) && rs1_hit_s;
  assign rs2_match_s = id_rs2_used_i && (id_rs2_i != {REG_AW{1'b0}}) && rs2_hit_s;
  assign stall_s     = id_valid_i && !flush_i &&
                       (rs1_match_s || rs2_match_s ||
                        (id_memread_i && full_s && !wb_load_valid_i));
  assign alloc_s     = id_valid_i && id_memread_i && !flush_i && !stall_s &&
                       (id_rd_i != {REG_AW{1'b0}});
  assign retire_s    = wb_load_valid_i && !empty_s;

  // Next-state: retire clears head first so a same-slot allocate (full case) wins.
  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    underflow_d = underflow_q | (wb_load_valid_i && empty_s);
    if (retire_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end
    if (alloc_s) begin
      valid_d[tail_q] = 1'b1;
      rd_d[tail_q]    = id_rd_i;
      tail_d          = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end
    case ({alloc_s, retire_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q     <= '0;
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= {REG_AW{1'b0}};
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign stall_o     = stall_s;
  assign full_o      = full_s;
  assign empty_o     = empty_s;
  assign count_o     = count_q;
  assign underflow_o = underflow_q;

`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cnt_q;

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                   stall_cnt_q <= 32'd0;
    else if (stall_cnt_clr_i)                       stall_cnt_q <= 32'd0;
    else if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    else                                            stall_cnt_q <= stall_cnt_q;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
